// File: rtl/parking_gate_arbiter.sv
// ---------------------------------------------------------------------------
// parking_gate_arbiter
//
// Arbitrates entry/exit vehicle-sensor requests toward the parking occupancy
// FSM. Each served request produces a one-cycle entry/exit pulse with its
// acknowledge. The shared gate then runs an open-hold phase and a close-clear
// phase before the next request is taken. Requests that cannot be served are
// rejected: entry while the lot is full, or exit from a slot that is free.
//
// Optional build macro:
//   PARKING_EXIT_PRIORITY_EN - when defined, exit always wins a tie between
//                              valid requests and there is no round-robin
//                              pointer. When undefined, ties alternate
//                              round-robin, with entry favoured after reset.
//
// Parameters:
//   OPEN_CYCLES   cycles gate_open is held per served request (1..15)
//   CLOSE_CYCLES  clear-out cycles after the gate closes (1..15)
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset          synchronous active-high reset
//   entry_req      entry request level, held until entry_ack
//   exit_req       exit request level, held until exit_ack
//   exit_slot_req  slot being vacated, valid while exit_req=1
//   spots          occupancy vector, 1 = occupied
//   capacity       remaining capacity (0..4; 5..7 count as nonzero)
//   entry_signal   one-cycle pulse: a car enters
//   exit_signal    one-cycle pulse: a car exits
//   exit_slot      registered slot that goes with exit_signal
//   entry_ack      one-cycle acknowledge of the entry request
//   exit_ack       one-cycle acknowledge of the exit request
//   entry_reject   pulses with entry_ack when the lot is full
//   exit_reject    pulses with exit_ack when the slot is already free
//   gate_open      gate actuator drive
//   busy           high in every state except IDLE
//
// States:
//   IDLE  | sample requests, grant one or reject the invalid ones
//   GRANT | one cycle: pulse and acknowledge go out
//   OPEN  | gate_open held for OPEN_CYCLES cycles
//   CLOSE | gate closed, clear-out for CLOSE_CYCLES cycles
// ---------------------------------------------------------------------------
module parking_gate_arbiter #(
    parameter int OPEN_CYCLES  = 4,
    parameter int CLOSE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_slot_req,
    input  logic [3:0] spots,
    input  logic [2:0] capacity,
    output logic       entry_signal,
    output logic       exit_signal,
    output logic [1:0] exit_slot,
    output logic       entry_ack,
    output logic       exit_ack,
    output logic       entry_reject,
    output logic       exit_reject,
    output logic       gate_open,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } state_t;

    localparam logic [3:0] OPEN_LOAD  = 4'(OPEN_CYCLES - 1);
    localparam logic [3:0] CLOSE_LOAD = 4'(CLOSE_CYCLES - 1);

    state_t     state, state_next;
    logic [3:0] phase_cnt, phase_cnt_next;
    logic [1:0] exit_slot_next;
    logic       entry_signal_next, exit_signal_next;
    logic       entry_ack_next, exit_ack_next;
    logic       entry_reject_next, exit_reject_next;
    logic       gate_open_next, busy_next;
    logic       entry_pending, exit_pending;
    logic       ev, xv;
    logic       pick_entry, pick_exit;
`ifndef PARKING_EXIT_PRIORITY_EN
    logic       rr_ptr, rr_ptr_next;
`endif

    // A request whose ack is on the outputs this cycle is the one just
    // answered; the requester drops it now, so it must not be seen twice.
    assign entry_pending = entry_req && !entry_ack;
    assign exit_pending  = exit_req && !exit_ack;
    assign ev            = entry_pending && (capacity != 3'd0);
    assign xv            = exit_pending && spots[exit_slot_req];

    always_comb begin
        state_next        = state;
        phase_cnt_next    = phase_cnt;
        exit_slot_next    = exit_slot;
        entry_signal_next = 1'b0;
        exit_signal_next  = 1'b0;
        entry_ack_next    = 1'b0;
        exit_ack_next     = 1'b0;
        entry_reject_next = 1'b0;
        exit_reject_next  = 1'b0;
        gate_open_next    = 1'b0;
        pick_entry        = 1'b0;
        pick_exit         = 1'b0;
`ifndef PARKING_EXIT_PRIORITY_EN
        rr_ptr_next       = rr_ptr;
`endif

        case (state)
            IDLE: begin
`ifdef PARKING_EXIT_PRIORITY_EN
                pick_exit  = xv;
                pick_entry = ev && !xv;
`else
                pick_entry = ev && (!xv || !rr_ptr);
                pick_exit  = xv && !pick_entry;
`endif
                if (pick_entry || pick_exit) begin
                    state_next        = GRANT;
                    exit_slot_next    = exit_slot_req;
                    entry_signal_next = pick_entry;
                    entry_ack_next    = pick_entry;
                    exit_signal_next  = pick_exit;
                    exit_ack_next     = pick_exit;
`ifndef PARKING_EXIT_PRIORITY_EN
                    rr_ptr_next       = pick_entry;
`endif
                end else begin
                    // Rejection only when nothing is granted this cycle.
                    entry_ack_next    = entry_pending && !ev;
                    entry_reject_next = entry_pending && !ev;
                    exit_ack_next     = exit_pending && !xv;
                    exit_reject_next  = exit_pending && !xv;
                end
            end
            GRANT: begin
                state_next     = OPEN;
                phase_cnt_next = OPEN_LOAD;
                gate_open_next = 1'b1;
            end
            OPEN: begin
                if (phase_cnt == 4'd0) begin
                    state_next     = CLOSE;
                    phase_cnt_next = CLOSE_LOAD;
                end else begin
                    phase_cnt_next = phase_cnt - 4'd1;
                    gate_open_next = 1'b1;
                end
            end
            CLOSE: begin
                if (phase_cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    phase_cnt_next = phase_cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            phase_cnt    <= 4'd0;
            exit_slot    <= 2'd0;
            entry_signal <= 1'b0;
            exit_signal  <= 1'b0;
            entry_ack    <= 1'b0;
            exit_ack     <= 1'b0;
            entry_reject <= 1'b0;
            exit_reject  <= 1'b0;
            gate_open    <= 1'b0;
            busy         <= 1'b0;
`ifndef PARKING_EXIT_PRIORITY_EN
            rr_ptr       <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            phase_cnt    <= phase_cnt_next;
            exit_slot    <= exit_slot_next;
            entry_signal <= entry_signal_next;
            exit_signal  <= exit_signal_next;
            entry_ack    <= entry_ack_next;
            exit_ack     <= exit_ack_next;
            entry_reject <= entry_reject_next;
            exit_reject  <= exit_reject_next;
            gate_open    <= gate_open_next;
            busy         <= busy_next;
`ifndef PARKING_EXIT_PRIORITY_EN
            rr_ptr       <= rr_ptr_next;
`endif
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// ---------------------------------------------------------------------------
// tb_parking_gate_arbiter
//
// Drives parking_gate_arbiter with directed scenarios followed by randomized
// requests, capacity/spot changes and occasional resets. A transaction-level
// reference model tracks the time elapsed since the last grant and derives
// every expected output from that age. All outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_parking_gate_arbiter;

    localparam int OPEN_C  = 4;
    localparam int CLOSE_C = 2;
    localparam int SERVICE = 1 + OPEN_C + CLOSE_C;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_req, exit_req;
    logic [1:0] exit_slot_req;
    logic [3:0] spots;
    logic [2:0] capacity;
    logic       entry_signal, exit_signal;
    logic [1:0] exit_slot;
    logic       entry_ack, exit_ack, entry_reject, exit_reject;
    logic       gate_open, busy;

    parking_gate_arbiter #(.OPEN_CYCLES(OPEN_C), .CLOSE_CYCLES(CLOSE_C)) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_slot_req (exit_slot_req),
        .spots         (spots),
        .capacity      (capacity),
        .entry_signal  (entry_signal),
        .exit_signal   (exit_signal),
        .exit_slot     (exit_slot),
        .entry_ack     (entry_ack),
        .exit_ack      (exit_ack),
        .entry_reject  (entry_reject),
        .exit_reject   (exit_reject),
        .gate_open     (gate_open),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: age = cycles since the grant edge (0 = idle).
    int         age = 0;
    bit         m_rr = 1'b0;
    logic [1:0] m_slot = 2'd0;
    bit e_esig, e_xsig, e_eack, e_xack, e_erej, e_xrej;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit ep, xp, ev, xv;
        int pick;
        ep = entry_req && !e_eack;
        xp = exit_req && !e_xack;
        {e_esig, e_xsig, e_eack, e_xack, e_erej, e_xrej} = '0;
        if (reset) begin
            age    = 0;
            m_rr   = 1'b0;
            m_slot = 2'd0;
        end else if (age == 0) begin
            ev   = ep && (capacity != 0);
            xv   = xp && (spots[exit_slot_req] == 1'b1);
            pick = 0;
            if (ev && xv) begin
`ifdef PARKING_EXIT_PRIORITY_EN
                pick = 2;
`else
                pick = m_rr ? 2 : 1;
`endif
            end else if (ev) pick = 1;
            else if (xv) pick = 2;
            if (pick != 0) begin
                age    = 1;
                m_slot = exit_slot_req;
                m_rr   = (pick == 1);
                e_esig = (pick == 1);
                e_eack = (pick == 1);
                e_xsig = (pick == 2);
                e_xack = (pick == 2);
            end else begin
                e_eack = ep && !ev;
                e_erej = ep && !ev;
                e_xack = xp && !xv;
                e_xrej = xp && !xv;
            end
        end else begin
            age = (age == SERVICE) ? 0 : age + 1;
        end
    endtask

    task automatic compare_all();
        check_val("entry_signal", entry_signal, e_esig);
        check_val("exit_signal",  exit_signal,  e_xsig);
        check_val("entry_ack",    entry_ack,    e_eack);
        check_val("exit_ack",     exit_ack,     e_xack);
        check_val("entry_reject", entry_reject, e_erej);
        check_val("exit_reject",  exit_reject,  e_xrej);
        check_val("gate_open",    gate_open,    (age >= 2 && age <= 1 + OPEN_C));
        check_val("busy",         busy,         (age != 0));
        if (age != 0) check_val("exit_slot", exit_slot, m_slot);
    endtask

    // One clock: predict, clock, sample 1 time unit later, requesters react.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (entry_ack) entry_req = 1'b0;
        if (exit_ack)  exit_req  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0;
        exit_slot_req = 2'd0; spots = 4'd0; capacity = 3'd0;
        #1;
        run(2);
        reset = 1'b0;
        run(2);

        // Plain entry with room.
        capacity = 3'd4; entry_req = 1'b1;
        run(10);

        // Lot full: entry rejected.
        capacity = 3'd0; entry_req = 1'b1;
        run(3);

        // Exit from a free slot is rejected, from an occupied one granted.
        capacity = 3'd4; spots = 4'b0101;
        exit_req = 1'b1; exit_slot_req = 2'd1;
        run(3);
        exit_req = 1'b1; exit_slot_req = 2'd2;
        run(10);

        // Simultaneous entry/exit pairs, then a tie with the pointer flipped.
        capacity = 3'd2; spots = 4'b0011;
        for (int p = 0; p < 2; p++) begin
            entry_req = 1'b1; exit_req = 1'b1; exit_slot_req = 2'd0;
            run(18);
        end
        entry_req = 1'b1;
        run(2);
        exit_req = 1'b1; entry_req = 1'b1;
        run(20);

        // Requests toggled while busy, then reset mid-OPEN with entry held.
        entry_req = 1'b1; capacity = 3'd4;
        run(3);
        for (int i = 0; i < 4; i++) begin
            entry_req = ~entry_req;
            run(1);
        end
        run(8);
        entry_req = 1'b1;
        run(3);
        reset = 1'b1; entry_req = 1'b1;
        run(2);
        reset = 1'b0;
        run(12);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            if (!entry_req && $urandom_range(0, 3) == 0) entry_req = 1'b1;
            if (!exit_req && $urandom_range(0, 3) == 0) begin
                exit_req      = 1'b1;
                exit_slot_req = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) capacity = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) spots    = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
